// File: rtl/i2s_rx.sv
// I2S capture receiver: oversamples bck/lclk/din on clk, deserializes WIDTH-bit
// left/right words and writes each complete stereo frame into a FIFO write port.
module i2s_rx #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               aclr,
  input  logic               bck,
  input  logic               lclk,
  input  logic               din,
  output logic [2*WIDTH-1:0] sample,
  output logic               wrreq,
  input  logic               wrfull,
  output logic               locked,
  output logic               frame_err,
  output logic               overflow
);

  // Counter is wide enough to see WIDTH+1 so over-long words are detectable.
  localparam int CW = $clog2(WIDTH + 1) + 1;
  localparam logic [CW-1:0] CNT_W = CW'(WIDTH);

  typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0] bck_sync_q, lclk_sync_q, din_sync_q;
  logic                   bck_prev_q;
  logic                   bck_s, lclk_s, din_s, bit_ev;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic [WIDTH-1:0]       left_sr_q, left_sr_d;
  logic [WIDTH-1:0]       right_sr_q, right_sr_d;
  logic [WIDTH-1:0]       left_q, left_d;
  logic                   lclk_prev_q, lclk_prev_d;
  logic                   emit_q, emit_d;
  logic [2*WIDTH-1:0]     sample_q, sample_d;
  logic                   wrreq_q, wrreq_d;
  logic                   locked_q, locked_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overflow_q, overflow_d;

  assign bck_s  = bck_sync_q[SYNC_STAGES-1];
  assign lclk_s = lclk_sync_q[SYNC_STAGES-1];
  assign din_s  = din_sync_q[SYNC_STAGES-1];
  assign bit_ev = bck_s & ~bck_prev_q;

  // Stage 0: input synchronizers and bck edge history
  always_ff @(posedge clk) begin
    if (aclr) begin
      bck_sync_q  <= '0;
      lclk_sync_q <= '0;
      din_sync_q  <= '0;
      bck_prev_q  <= 1'b0;
    end else begin
      bck_sync_q  <= {bck_sync_q[SYNC_STAGES-2:0], bck};
      lclk_sync_q <= {lclk_sync_q[SYNC_STAGES-2:0], lclk};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], din};
      bck_prev_q  <= bck_s;
    end
  end

  // Stage 1: framing FSM on bit events; stage 2: emit one clk after completion
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cnt_inc     = sat_inc(cnt_q);
    left_sr_d   = left_sr_q;
    right_sr_d  = right_sr_q;
    left_d      = left_q;
    lclk_prev_d = lclk_prev_q;
    emit_d      = 1'b0;
    sample_d    = sample_q;
    wrreq_d     = 1'b0;
    locked_d    = locked_q;
    frame_err_d = frame_err_q;
    overflow_d  = overflow_q;

    if (emit_q) begin
      sample_d = {left_q, right_sr_q};
      if (wrfull) begin
        overflow_d = 1'b1;
      end else begin
        wrreq_d  = 1'b1;
        locked_d = 1'b1;
      end
    end

    if (bit_ev) begin
      lclk_prev_d = lclk_s;
      case (state_q)
        HUNT: begin
          if (lclk_prev_q && !lclk_s) begin
            state_d = LEFT;
            cnt_d   = '0;
          end
        end
        LEFT: begin
          if (cnt_q < CNT_W) left_sr_d = {left_sr_q[WIDTH-2:0], din_s};
          cnt_d = cnt_inc;
          if (!lclk_prev_q && lclk_s) begin
            cnt_d = '0;
            if (cnt_inc == CNT_W) begin
              left_d  = left_sr_d;
              state_d = RIGHT;
            end else begin
              frame_err_d = 1'b1;
              locked_d    = 1'b0;
              state_d     = HUNT;
            end
          end
        end
        RIGHT: begin
          if (cnt_q < CNT_W) right_sr_d = {right_sr_q[WIDTH-2:0], din_s};
          cnt_d = cnt_inc;
          // The closing 1->0 edge also opens the next left word.
          if (lclk_prev_q && !lclk_s) begin
            cnt_d = '0;
            if (cnt_inc == CNT_W) begin
              state_d = LEFT;
              emit_d  = 1'b1;
            end else begin
              frame_err_d = 1'b1;
              locked_d    = 1'b0;
              state_d     = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q     <= HUNT;
      cnt_q       <= '0;
      left_sr_q   <= '0;
      right_sr_q  <= '0;
      left_q      <= '0;
      lclk_prev_q <= 1'b0;
      emit_q      <= 1'b0;
      sample_q    <= '0;
      wrreq_q     <= 1'b0;
      locked_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      left_sr_q   <= left_sr_d;
      right_sr_q  <= right_sr_d;
      left_q      <= left_d;
      lclk_prev_q <= lclk_prev_d;
      emit_q      <= emit_d;
      sample_q    <= sample_d;
      wrreq_q     <= wrreq_d;
      locked_q    <= locked_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  assign sample    = sample_q;
  assign wrreq     = wrreq_q;
  assign locked    = locked_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives an I2S stream from tasks and checks
// captured frames, status flags and emit latency against hand-computed values.
module tb_i2s_rx;
  localparam int WIDTH = 32;
  localparam int SYNC  = 2;

  logic               clk = 1'b0;
  logic               aclr, bck, lclk, din, wrfull;
  logic [2*WIDTH-1:0] sample;
  logic               wrreq, locked, frame_err, overflow;

  int n_chk = 0;
  int n_err = 0;
  int half  = 8;
  int lat;
  logic [2*WIDTH-1:0] got_q[$];

  always #5 clk = ~clk;

  i2s_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .aclr(aclr), .bck(bck), .lclk(lclk), .din(din),
    .sample(sample), .wrreq(wrreq), .wrfull(wrfull),
    .locked(locked), .frame_err(frame_err), .overflow(overflow)
  );

  always @(negedge clk) if (wrreq === 1'b1) got_q.push_back(sample);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pop_s();
    if (got_q.size() > 0) return got_q.pop_front();
    return '0;
  endfunction

  task automatic send_bit(input logic d, input logic l);
    bck = 1'b0; din = d; lclk = l;
    repeat (half) @(negedge clk);
    bck = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  // n bits MSB first; lclk flips on the LSB (one-bit I2S delay).
  task automatic send_word(input logic [31:0] v, input int n, input logic ch);
    logic b;
    for (int i = n - 1; i >= 0; i--) begin
      b = (i < WIDTH) ? v[i] : 1'b0;
      send_bit(b, (i == 0) ? ~ch : ch);
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r);
    send_word(l, 32, 1'b0);
    send_word(r, 32, 1'b1);
  endtask

  task automatic do_reset();
    aclr = 1'b1;
    @(negedge clk);
    aclr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    aclr = 1'b1; bck = 1'b0; lclk = 1'b0; din = 1'b0; wrfull = 1'b0;
    repeat (3) @(negedge clk);
    aclr = 1'b0;
    chk("rst_sample", 64'(sample), 64'h0);
    chk("rst_wrreq", 64'(wrreq), 64'h0);
    chk("rst_locked", 64'(locked), 64'h0);
    chk("rst_frame_err", 64'(frame_err), 64'h0);
    chk("rst_overflow", 64'(overflow), 64'h0);

    // Nominal frame with latency measurement on the closing bit
    send_word(32'h0, 32, 1'b1);
    send_word(32'h12345678, 32, 1'b0);
    r = 32'h9ABCDEF0;
    for (int i = 31; i >= 1; i--) send_bit(r[i], 1'b1);
    bck = 1'b0; din = r[0]; lclk = 1'b0;
    repeat (half) @(negedge clk);
    bck = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (wrreq === 1'b1) begin lat = k; break; end
    end
    chk("nom_latency", 64'(lat), 64'(SYNC + 2));
    @(negedge clk);
    repeat (half) @(negedge clk);
    repeat (8) @(negedge clk);
    chk("nom_count", 64'(got_q.size()), 64'd1);
    chk("nom_sample", pop_s(), 64'h123456789ABCDEF0);
    chk("nom_locked", 64'(locked), 64'h1);
    chk("nom_frame_err", 64'(frame_err), 64'h0);
    chk("nom_overflow", 64'(overflow), 64'h0);

    // Startup mid-frame: reset released inside a right word
    got_q.delete();
    aclr = 1'b1;
    r = 32'h55555555;
    for (int i = 31; i >= 22; i--) send_bit(r[i], 1'b1);
    aclr = 1'b0;
    for (int i = 21; i >= 1; i--) send_bit(r[i], 1'b1);
    send_bit(r[0], 1'b0);
    for (int f = 0; f < 3; f++) send_frame(32'hAAAAAAAA, 32'h55555555);
    repeat (8) @(negedge clk);
    chk("mid_count", 64'(got_q.size()), 64'd3);
    for (int f = 0; f < 3; f++) chk("mid_sample", pop_s(), 64'hAAAAAAAA55555555);
    chk("mid_locked", 64'(locked), 64'h1);

    // Short left word
    got_q.delete();
    send_word(32'hCAFEF00D, 31, 1'b0);
    repeat (8) @(negedge clk);
    chk("short_frame_err", 64'(frame_err), 64'h1);
    chk("short_locked", 64'(locked), 64'h0);
    send_word(32'h13572468, 32, 1'b1);
    repeat (8) @(negedge clk);
    chk("short_no_wrreq", 64'(got_q.size()), 64'd0);
    send_frame(32'h0BADBEEF, 32'h13579BDF);
    repeat (8) @(negedge clk);
    chk("short_recover_count", 64'(got_q.size()), 64'd1);
    chk("short_recover_sample", pop_s(), 64'h0BADBEEF13579BDF);
    chk("short_recover_locked", 64'(locked), 64'h1);
    chk("short_err_sticky", 64'(frame_err), 64'h1);

    // Overflow: two frames dropped, then one accepted
    got_q.delete();
    wrfull = 1'b1;
    send_frame(32'h11111111, 32'h22222222);
    send_frame(32'h11111111, 32'h22222222);
    repeat (8) @(negedge clk);
    chk("ovf_count", 64'(got_q.size()), 64'd0);
    chk("ovf_flag", 64'(overflow), 64'h1);
    chk("ovf_locked", 64'(locked), 64'h1);
    chk("ovf_sample_upd", 64'(sample), 64'h1111111122222222);
    wrfull = 1'b0;
    send_frame(32'h33333333, 32'h44444444);
    repeat (8) @(negedge clk);
    chk("ovf_recover_count", 64'(got_q.size()), 64'd1);
    chk("ovf_recover_sample", pop_s(), 64'h3333333344444444);
    chk("ovf_sticky", 64'(overflow), 64'h1);

    // Reset during bit 10 of a right word
    got_q.delete();
    send_word(32'h0A0A0A0A, 32, 1'b0);
    r = 32'h5A5A5A5A;
    for (int i = 31; i >= 22; i--) send_bit(r[i], 1'b1);
    do_reset();
    chk("mrst_sample", 64'(sample), 64'h0);
    chk("mrst_wrreq", 64'(wrreq), 64'h0);
    chk("mrst_locked", 64'(locked), 64'h0);
    chk("mrst_frame_err", 64'(frame_err), 64'h0);
    chk("mrst_overflow", 64'(overflow), 64'h0);
    for (int i = 21; i >= 1; i--) send_bit(r[i], 1'b1);
    send_bit(r[0], 1'b0);
    send_frame(32'h600DCAFE, 32'h0123ABCD);
    repeat (8) @(negedge clk);
    chk("mrst_count", 64'(got_q.size()), 64'd1);
    chk("mrst_sample_after", pop_s(), 64'h600DCAFE0123ABCD);

    // Long right word
    got_q.delete();
    send_word(32'h76543210, 32, 1'b0);
    send_word(32'hFEDCBA98, 33, 1'b1);
    repeat (8) @(negedge clk);
    chk("long_frame_err", 64'(frame_err), 64'h1);
    chk("long_count", 64'(got_q.size()), 64'd0);
    chk("long_locked", 64'(locked), 64'h0);

    // bck = clk/4
    do_reset();
    half = 2;
    got_q.delete();
    send_word(32'h0, 32, 1'b1);
    send_frame(32'hDEADBEEF, 32'h0F1E2D3C);
    send_frame(32'h80000001, 32'h7FFFFFFE);
    repeat (8) @(negedge clk);
    chk("fast_count", 64'(got_q.size()), 64'd2);
    chk("fast_sample0", pop_s(), 64'hDEADBEEF0F1E2D3C);
    chk("fast_sample1", pop_s(), 64'h800000017FFFFFFE);
    chk("fast_locked", 64'(locked), 64'h1);
    chk("fast_frame_err", 64'(frame_err), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
I2S receiver for the capture path, the counterpart to the audio output transmitter. It oversamples an external I2S stream (bck, lclk, din) on the single system clock and deserializes 32-bit left/right words. Each completed stereo frame is packed into one 64-bit sample and pushed into the downstream audio-in FIFO through a wrreq/wrfull write port. Sticky status flags report framing errors and FIFO overflow.

Parameters:
WIDTH, 32, bits per channel word; frame = 2*WIDTH bits
SYNC_STAGES, 2, synchronizer flops on bck, lclk, din (min 2)

Ports:
clk  input  1  system clock; must be >= 4x bck frequency (e.g. 50 MHz vs 3.072 MHz)
aclr  input  1  reset, synchronous, active-high
bck  input  1  I2S bit clock, asynchronous to clk
lclk  input  1  I2S word select; 0 = left, 1 = right
din  input  1  I2S serial data, MSB first
sample  output  2*WIDTH  {left, right}; left in [2*WIDTH-1:WIDTH]
wrreq  output  1  one-clk pulse: sample valid, write to FIFO
wrfull  input  1  FIFO full; sampled in the wrreq cycle
locked  output  1  high while frames are being received correctly
frame_err  output  1  sticky: channel word with bit count != WIDTH
overflow  output  1  sticky: frame dropped because wrfull=1

Behaviour:
- Reset (aclr=1 at clk edge): sample=0, wrreq=0, locked=0, frame_err=0, overflow=0; synchronizer flops=0, shift register=0, bit counter=0, state=HUNT, lclk_prev=0. Applies mid-frame; the partial frame is discarded.
- Synchronization: bck, lclk, din each pass through SYNC_STAGES flops. A bck rise is detected when the previous synchronized bck=0 and the current synchronized bck=1. On a bck rise, synchronized din and lclk are captured together ("bit event"). No other logic uses the raw inputs.
- I2S framing: the bit captured on the bit event where lclk first differs from lclk_prev is the LSB of the ending word. The next bit event carries the MSB of the new word. lclk_prev updates on every bit event.
- Bit counter cnt counts bits captured in the current word, including the LSB captured on the transition event. Bits past WIDTH are counted but not shifted in.
- States:
  - HUNT: ignore data. On a 1->0 lclk transition event, go to LEFT with cnt=0. A 0->1 transition does not lock.
  - LEFT: on each bit event, shift din into left_sr when cnt<WIDTH, then cnt++. On a 0->1 transition event, include that bit, then check the total. If total == WIDTH, latch left and go to RIGHT with cnt=0. Otherwise set frame_err, clear locked, and go to HUNT.
  - RIGHT: same rules into right_sr, ending on a 1->0 transition. If total == WIDTH, the frame is complete: go directly to LEFT with cnt=0 (the same transition starts the new left word), then emit. Otherwise set frame_err, clear locked, and go to HUNT.
- Emit: on the clk cycle after the completing bit event, sample <= {left, right}.
  - If wrfull=0 in that cycle: wrreq=1 for exactly one cycle, locked<=1.
  - If wrfull=1: wrreq stays 0, overflow<=1, frame dropped, locked unchanged.
  - sample holds its value until the next emit.
- Latency: din/lclk pin change to bit event = SYNC_STAGES+1 clk. Completing bit event to wrreq = 1 clk.
- frame_err and overflow clear only on aclr.
- Simultaneous aclr with a bit event or emit: reset wins, and no wrreq is issued.
- bck stopped: no events occur, state holds, and locked stays at its last value.

Test Plan:
- Nominal: after one aligning frame, send L=0x12345678, R=0x9ABCDEF0 at bck = clk/16 -> exactly one wrreq pulse; sample=0x123456789ABCDEF0; locked=1; flags 0. Check the pulse comes 1 clk after the last bit event.
- Startup mid-frame: release aclr during a right word, then send 3 good frames (0xAAAAAAAA/0x55555555) -> no wrreq for the partial frame; 3 pulses follow with the correct data.
- Short word: left word of 31 bits, then normal traffic -> frame_err=1, locked=0, no wrreq for that frame; the next full frame after the 1->0 lclk edge gives wrreq and locked=1, while frame_err stays 1.
- Overflow: hold wrfull=1 across 2 frames, then release -> no wrreq and overflow=1 for those frames; the next frame gives wrreq with correct data, and overflow stays 1.
- Reset mid-operation: assert aclr for 1 clk during bit 10 of a right word -> all outputs 0 and state HUNT; the first frame after the next 1->0 lclk edge is received correctly.
- Long word and clock ratio: send a 33-bit right word -> frame_err=1. Run nominal traffic at bck = clk/4 -> correct samples, no missed bits.
